// File: rtl/popcount_accum.sv
// Frame accumulator for one-hot ones-counts: sums decoded beats per frame and
// counts them, both saturating, then holds the result until the consumer takes it.
module popcount_accum #(
  parameter int ACC_W  = 8,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        onehot,
  input  logic              in_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [WCNT_W-1:0] beats,
  output logic              sat,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [ACC_W-1:0]  SUM_MAX   = {ACC_W{1'b1}};
  localparam logic [WCNT_W-1:0] BEATS_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   sum_reg, sum_next;
  logic [WCNT_W-1:0]  beats_reg, beats_next;
  logic               sat_reg, sat_next;
  logic               err_reg, err_next;

  logic [2:0]         dec_val;
  logic               dec_bad;
  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic               sum_ovf;
  logic               beats_full;

  always_comb begin
    dec_val = 3'd0;
    dec_bad = 1'b0;
    case (onehot)
      5'b00001: dec_val = 3'd0;
      5'b00010: dec_val = 3'd1;
      5'b00100: dec_val = 3'd2;
      5'b01000: dec_val = 3'd3;
      5'b10000: dec_val = 3'd4;
      default:  dec_bad = 1'b1;
    endcase
  end

  assign in_ready = ena & (state_reg != OUT);
  assign accept   = in_valid & in_ready;

  // ACC_W >= 3 keeps sum + 4 below 2^(ACC_W+1), so the carry bit alone flags overflow.
  assign sum_ext    = {1'b0, sum_reg} + {{(ACC_W-2){1'b0}}, dec_val};
  assign sum_ovf    = sum_ext[ACC_W];
  assign beats_full = &beats_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      beats_reg <= '0;
      sat_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      beats_reg <= beats_next;
      sat_reg   <= sat_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ACC: if (accept) state_next = in_last ? OUT : ACC;
      OUT:       if (ena && sum_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // accept already implies ena, so results stay frozen whenever ena is low.
  always_comb begin
    sum_next   = sum_reg;
    beats_next = beats_reg;
    sat_next   = sat_reg;
    err_next   = err_reg;
    if (accept) begin
      if (state_reg == IDLE) begin
        sum_next   = {{(ACC_W-3){1'b0}}, dec_val};
        beats_next = BEATS_ONE;
        sat_next   = 1'b0;
        err_next   = dec_bad;
      end else begin
        sum_next   = sum_ovf ? SUM_MAX : sum_ext[ACC_W-1:0];
        beats_next = beats_full ? beats_reg : beats_reg + BEATS_ONE;
        sat_next   = sat_reg | sum_ovf | beats_full;
        err_next   = err_reg | dec_bad;
      end
    end
  end

  always_comb begin
    sum_valid = (state_reg == OUT);
    sum       = sum_reg;
    beats     = beats_reg;
    sat       = sat_reg;
    err       = err_reg;
  end

endmodule
